activation_fp16_lanes: RTL and testbench

- Parametrised, multi-lane, pipelined FP16 (IEEE binary16) activation unit for the conv datapath. It sits between the accumulator/bias stage and the pooling/writeback stage.
- Applies one of NONE / ReLU / LeakyReLU / ReLU6 to LANES values per beat, with a valid/ready handshake, full throughput and a fixed 2-cycle latency.
- Mode is captured per beat, so the mode can change between back-to-back beats without draining.
- Pure bit-level FP16 logic; no vendor FP cores.

---
 rtl/activation_fp16_lanes.sv | 84 ++++++++
 tb/tb_activation_fp16_lanes.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/activation_fp16_lanes.sv
// activation_fp16_lanes: 2-stage multi-lane FP16 NONE/ReLU/LeakyReLU/ReLU6 unit with valid/ready flow control.
// Optional ACT_STATS_EN adds stat_clr/stat_zero_cnt counting zero-valued output lanes.
module activation_fp16_lanes #(
  parameter int LANES = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_mode,
  input  logic [LANES*16-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*16-1:0] out_data
`ifdef ACT_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_zero_cnt
`endif
);
  localparam logic [4:0] LS = 5'(LEAK_SHIFT);
  logic s1_valid, s1_en, s2_en;
  logic [2:0] s1_mode;
  logic [LANES*16-1:0] s1_data, res;
  logic [LANES-1:0] nan_c, inf_c, small_c, gt6_c, s1_nan, s1_inf, s1_small, s1_gt6;
  assign s2_en = !out_valid || out_ready;
  assign s1_en = !s1_valid || s2_en;
  assign in_ready = s1_en;
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      nan_c[i] = &in_data[16*i+10 +: 5] && |in_data[16*i +: 10];
      inf_c[i] = &in_data[16*i+10 +: 5] && ~|in_data[16*i +: 10];
      small_c[i] = in_data[16*i+10 +: 5] <= LS;
      gt6_c[i] = in_data[16*i +: 15] > 15'h4600;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid <= 1'b0;
    else if (s1_en) s1_valid <= in_valid;
  end
  always_ff @(posedge clk) begin
    if (s1_en && in_valid) begin
      s1_data <= in_data;
      s1_mode <= in_mode;
      s1_nan <= nan_c;
      s1_inf <= inf_c;
      s1_small <= small_c;
      s1_gt6 <= gt6_c;
    end
  end
  // Priority: NaN, negative clamps, ReLU6 ceiling, LeakyReLU scaling, passthrough
  always_comb begin
    res = '0;
    for (int i = 0; i < LANES; i++)
      res[16*i +: 16] = s1_nan[i] ? 16'h7E00 :
        (s1_mode == 3'd1 || s1_mode == 3'd3) && s1_data[16*i+15] ? 16'h0000 :
        s1_mode == 3'd3 && s1_gt6[i] ? 16'h4600 :
        s1_mode == 3'd2 && s1_data[16*i+15] ? (s1_inf[i] ? 16'hFC00 : s1_small[i] ? 16'h8000 :
          {1'b1, s1_data[16*i+10 +: 5] - LS, s1_data[16*i +: 10]}) :
        s1_data[16*i +: 16];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= res;
    end
  end
`ifdef ACT_STATS_EN
  logic [32:0] zeros, sum;
  always_comb begin
    zeros = '0;
    for (int i = 0; i < LANES; i++) zeros = zeros + 33'(out_data[16*i +: 15] == 15'h0);
    sum = {1'b0, stat_zero_cnt} + zeros;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) stat_zero_cnt <= '0;
    else if (out_valid && out_ready) stat_zero_cnt <= sum[32] ? '1 : sum[31:0];
  end
`endif
endmodule

// File: tb/tb_activation_fp16_lanes.sv
// tb_activation_fp16_lanes: directed + streamed scoreboard bench for activation_fp16_lanes.
module tb_activation_fp16_lanes;
  localparam int LANES = 4;
  localparam int LEAK_SHIFT = 3;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [2:0] in_mode = 0;
  logic [LANES*16-1:0] in_data = '0, out_data;
  logic [63:0] q[$];
  int compared = 0, mismatched = 0;
`ifdef ACT_STATS_EN
  logic stat_clr = 0;
  logic [31:0] stat_zero_cnt;
`endif
  activation_fp16_lanes #(.LANES(LANES), .LEAK_SHIFT(LEAK_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ACT_STATS_EN
    , .stat_clr(stat_clr), .stat_zero_cnt(stat_zero_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] model(input logic [2:0] m, input logic [15:0] x);
    logic [4:0] e;
    e = x[14:10];
    if (e == 5'd31 && x[9:0] != 0) return 16'h7E00;
    case (m)
      3'd1: return x[15] ? 16'h0000 : x;
      3'd2: begin
        if (!x[15]) return x;
        if (e == 5'd31) return 16'hFC00;
        if (int'(e) > LEAK_SHIFT) return {1'b1, 5'(int'(e) - LEAK_SHIFT), x[9:0]};
        return 16'h8000;
      end
      3'd3: return x[15] ? 16'h0000 : (x[14:0] > 15'h4600 ? 16'h4600 : x);
      default: return x;
    endcase
  endfunction
  function automatic logic [63:0] model_beat(input logic [2:0] m, input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < LANES; i++) r[16*i +: 16] = model(m, d[16*i +: 16]);
    return r;
  endfunction
  // Every cycle with a valid output is compared against the queue head, which also proves stall stability
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) check("unexpected_beat", {63'd0, out_valid}, 64'd0);
      else begin
        check("beat", out_data, q[0]);
        if (out_ready) void'(q.pop_front());
      end
    end
  end
  task automatic send(input logic [2:0] m, input logic [63:0] d, input logic [63:0] e, input bit rnd);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    in_valid = 1;
    in_mode = m;
    in_data = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) q.push_back(e);
      @(posedge clk);
      #1;
      n++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 0;
    check("accept", {63'd0, acc}, 64'd1);
  endtask
  task automatic drain();
    int n;
    n = 0;
    out_ready = 1;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    send(3'd1, 64'hBC00_3C00_8000_4700, 64'h0000_3C00_0000_4700, 0);
    check("lat_first_edge", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 check("lat_second_edge", {63'd0, out_valid}, 64'd1);
    drain();
    send(3'd2, 64'hC000_BC00_8001_FC00, 64'hB400_B000_8000_FC00, 0);
    send(3'd1, 64'h7C01_FE00_3C00_0000, 64'h7E00_7E00_3C00_0000, 0);
    send(3'd2, 64'h8C00_9000_8000_3C00, 64'h8000_8400_8000_3C00, 0);
    send(3'd3, 64'h4700_4600_7C00_C500, 64'h4600_4600_4600_0000, 0);
    send(3'd5, 64'hBC00_8000_FC00_7C00, 64'hBC00_8000_FC00_7C00, 0);
    send(3'd0, 64'h8000_FC00_7C00_0001, 64'h8000_FC00_7C00_0001, 0);
    send(3'd3, 64'h7C02_45FF_4601_0000, 64'h7E00_45FF_4600_0000, 0);
    drain();
    for (int b = 0; b < 16; b++) begin
      logic [63:0] d;
      logic [2:0] m;
      d = {$urandom, $urandom};
      m = 3'(b % 4);
      send(m, d, model_beat(m, d), 1);
    end
    drain();
    out_ready = 0;
    send(3'd1, 64'h3C00_BC00_3C00_BC00, 64'h3C00_0000_3C00_0000, 0);
    send(3'd0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0);
    rst_n = 0;
    q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check("midrst_idle", {63'd0, out_valid}, 64'd0);
    end
    send(3'd2, 64'hC000_4000_0000_8400, 64'hB400_4000_0000_8000, 0);
    drain();
`ifdef ACT_STATS_EN
    stat_clr = 1;
    @(posedge clk);
    #1 stat_clr = 0;
    check("stat_clr", 64'(stat_zero_cnt), 64'd0);
    for (int b = 0; b < 3; b++) send(3'd1, 64'hBC00_3C00_BC00_0000, 64'h0000_3C00_0000_0000, 0);
    drain();
    check("stat_nine", 64'(stat_zero_cnt), 64'd9);
    out_ready = 0;
    send(3'd1, 64'hBC00_3C00_BC00_0000, 64'h0000_3C00_0000_0000, 0);
    for (int c = 0; c < 10 && !out_valid; c++) @(posedge clk);
    #1 stat_clr = 1;
    out_ready = 1;
    @(posedge clk);
    #1 stat_clr = 0;
    check("stat_clr_wins", 64'(stat_zero_cnt), 64'd0);
    drain();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
